// File: rtl/div_phase_cnt.sv
// Phase counter for the clock-enable divider: owns cnt, end-of-period detection,
// the shadow ratio (with clamping) and the active ratio that is adopted at period starts.
module div_phase_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [DIV_W-1:0] div_val,
  output logic [DIV_W-1:0] cnt_next,
  output logic [DIV_W-1:0] ratio_next,
  output logic             at_end,
  output logic             clamp_hit
);

  localparam logic [DIV_W-1:0] RATIO_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] ratio_reg;
  logic [DIV_W-1:0] shadow_reg;
  logic [DIV_W-1:0] shadow_next;

  assign clamp_hit   = load && (div_val < RATIO_MIN);
  assign shadow_next = !load ? shadow_reg : (clamp_hit ? RATIO_MIN : div_val);
  assign at_end      = (cnt_reg == (ratio_reg - ONE));

  // A load on the same edge as a period start feeds straight into the new period.
  always_comb begin
    cnt_next   = cnt_reg;
    ratio_next = ratio_reg;
    if (start) begin
      cnt_next   = '0;
      ratio_next = shadow_next;
    end else if (run) begin
      if (at_end) begin
        cnt_next = '0;
        if (!stop) begin
          ratio_next = shadow_next;
        end
      end else begin
        cnt_next = cnt_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_reg    <= '0;
      ratio_reg  <= RATIO_MIN;
      shadow_reg <= RATIO_MIN;
    end else begin
      cnt_reg    <= cnt_next;
      ratio_reg  <= ratio_next;
      shadow_reg <= shadow_next;
    end
  end

endmodule

// File: rtl/div_clk_en_gen.sv
// Programmable clock-enable divider: registered divided level, rise/fall enables
// and a 2-bit period counter, all in the clk domain.
module div_clk_en_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             load,
  output logic             clk_div,
  output logic             ce_rise,
  output logic             ce_fall,
  output logic [1:0]       tick_cnt,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]       state_reg;
  logic             clk_div_reg;
  logic             ce_rise_reg;
  logic             ce_fall_reg;
  logic [1:0]       tick_cnt_reg;
  logic             busy_reg;
  logic             cfg_err_reg;

  logic             running;
  logic             start_now;
  logic             stop_now;
  logic             active_next;
  logic             rise_next;
  logic             at_end;
  logic             clamp_hit;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] ratio_next;
  logic [DIV_W-1:0] hi_next;

  assign running   = (state_reg == ST_RUN) || (state_reg == ST_STOP);
  assign start_now = (state_reg == ST_IDLE) && en;
  // Only a stop request that survives to the last cycle of a period ends the run.
  assign stop_now  = (state_reg == ST_STOP) && !en && at_end;

  assign active_next = start_now || (running && !stop_now);
  assign rise_next   = start_now || (running && at_end && !stop_now);
  assign hi_next     = ratio_next >> 1;

  div_phase_cnt #(
    .DIV_W (DIV_W)
  ) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (running),
    .start      (start_now),
    .stop       (stop_now),
    .load       (load),
    .div_val    (div_val),
    .cnt_next   (cnt_next),
    .ratio_next (ratio_next),
    .at_end     (at_end),
    .clamp_hit  (clamp_hit)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= ST_IDLE;
      clk_div_reg  <= 1'b0;
      ce_rise_reg  <= 1'b0;
      ce_fall_reg  <= 1'b0;
      tick_cnt_reg <= 2'd0;
      busy_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (en) state_reg <= ST_RUN;
        ST_RUN:  if (!en) state_reg <= ST_STOP;
        ST_STOP: begin
          if (en) begin
            state_reg <= ST_RUN;
          end else if (at_end) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Outputs are decoded from the next phase so they line up with cnt after the edge.
      clk_div_reg <= active_next && (cnt_next < hi_next);
      ce_fall_reg <= active_next && (cnt_next == hi_next);
      ce_rise_reg <= rise_next;
      busy_reg    <= active_next;
      if (rise_next) begin
        tick_cnt_reg <= tick_cnt_reg + 2'd1;
      end
      if (clamp_hit) begin
        cfg_err_reg <= 1'b1;
      end
    end
  end

  assign clk_div  = clk_div_reg;
  assign ce_rise  = ce_rise_reg;
  assign ce_fall  = ce_fall_reg;
  assign tick_cnt = tick_cnt_reg;
  assign busy     = busy_reg;
  assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_div_clk_en_gen.sv
// Bench for div_clk_en_gen: directed scenarios plus random traffic, checked every
// cycle against a period-level model that queues each period's expected waveform.
module tb_div_clk_en_gen;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             clk_div;
  logic             ce_rise;
  logic             ce_fall;
  logic [1:0]       tick_cnt;
  logic             busy;
  logic             cfg_err;

  div_clk_en_gen #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .load     (load),
    .clk_div  (clk_div),
    .ce_rise  (ce_rise),
    .ce_fall  (ce_fall),
    .tick_cnt (tick_cnt),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each started period pushes its whole {clk_div, ce_rise, ce_fall} sequence.
  typedef struct packed {
    logic cd;
    logic cr;
    logic cf;
  } wv_t;

  wv_t wave[$];
  bit  m_run;
  bit  m_stop;
  int  m_shadow;
  int  m_len;
  int  m_tick;
  bit  m_err;

  function automatic void model_reset();
    wave.delete();
    m_run    = 0;
    m_stop   = 0;
    m_shadow = 2;
    m_len    = 0;
    m_tick   = 0;
    m_err    = 0;
  endfunction

  function automatic void start_period(input int n);
    wv_t w;
    for (int i = 0; i < n; i++) begin
      w.cd = (i < n / 2);
      w.cr = (i == 0);
      w.cf = (i == n / 2);
      wave.push_back(w);
    end
    m_len  = n;
    m_tick = (m_tick + 1) % 4;
  endfunction

  function automatic int cur_cnt();
    return m_len - wave.size();
  endfunction

  function automatic void model_edge(input bit e, input bit ld, input int dv);
    int nsh;
    nsh = m_shadow;
    if (ld) begin
      nsh = (dv < 2) ? 2 : dv;
      if (dv < 2) m_err = 1;
    end
    if (!m_run) begin
      if (e) begin
        start_period(nsh);
        m_run = 1;
      end
    end else begin
      void'(wave.pop_front());
      if (wave.size() == 0) begin
        if (m_stop && !e) m_run = 0;
        else start_period(nsh);
      end
    end
    m_stop   = !e;
    m_shadow = nsh;
  endfunction

  task automatic check_all();
    wv_t w;
    w = '0;
    if (m_run) w = wave[0];
    chk("clk_div",  clk_div,  w.cd);
    chk("ce_rise",  ce_rise,  w.cr);
    chk("ce_fall",  ce_fall,  w.cf);
    chk("tick_cnt", tick_cnt, m_tick);
    chk("busy",     busy,     m_run);
    chk("cfg_err",  cfg_err,  m_err);
  endtask

  task automatic step(input bit e, input bit ld, input int dv);
    en      = e;
    load    = ld;
    div_val = dv[DIV_W-1:0];
    @(posedge clk);
    model_edge(e, ld, dv);
    @(negedge clk);
    $display("cyc e=%0b ld=%0b dv=%0d -> clk_div=%0b rise=%0b fall=%0b tick=%0d busy=%0b err=%0b",
             e, ld, dv, clk_div, ce_rise, ce_fall, tick_cnt, busy, cfg_err);
    check_all();
  endtask

  // Called at a negedge; asserts reset mid-low-phase and checks outputs before any edge.
  task automatic async_reset();
    #2 rst_n = 1'b1;
    #1;
    chk("rst_clk_div",  clk_div,  0);
    chk("rst_ce_rise",  ce_rise,  0);
    chk("rst_ce_fall",  ce_fall,  0);
    chk("rst_tick_cnt", tick_cnt, 0);
    chk("rst_busy",     busy,     0);
    chk("rst_cfg_err",  cfg_err,  0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    check_all();
  endtask

  task automatic wait_cnt(input int target, input bit e);
    int guard;
    guard = 0;
    while (!(m_run && cur_cnt() == target) && guard < 600) begin
      step(e, 0, 0);
      guard++;
    end
    chk("wait_cnt_timeout", (guard < 600), 1);
  endtask

  initial begin
    bit re;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // N=4 run over five periods
    step(0, 1, 4);
    for (int i = 0; i < 20; i++) step(1, 0, 0);

    // drop en at cnt=1, finish period, go idle
    wait_cnt(1, 1);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);

    // restart, drop en, re-raise while stopping
    step(1, 0, 0);
    wait_cnt(1, 1);
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // odd ratio, then change mid-period
    step(1, 1, 5);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    wait_cnt(1, 1);
    step(1, 1, 6);
    for (int i = 0; i < 15; i++) step(1, 0, 0);

    // async reset mid-run
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // clamp and sticky error
    step(1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 1, 4);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    async_reset();

    // random traffic
    re = 0;
    for (int i = 0; i < 3000; i++) begin
      bit ld;
      int dv;
      if ($urandom_range(0, 15) == 0) re = ~re;
      ld = ($urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 9));
      step(re, ld, dv);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    load = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_clk_en_gen.md
Name: div_clk_en_gen

Overview:
- Programmable clock-enable divider that sits directly upstream of the divided-clock counter stage.
- Produces a registered divided clock level plus single-cycle rise/fall enables in the `clk` domain, so downstream logic can run on `clk` gated by `ce_rise` instead of on a derived clock.
- Also provides a 2-bit period counter (0..3, wrapping), so the downstream count is available without a separate clock domain.

Parameters:
- DIV_W, 8, width of the divide-ratio field; legal ratio N = 2 .. 2^DIV_W-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset: one clock; reset is asynchronous and active-high (rst_n==1 resets)
- en  input  1  run request, level
- div_val  input  DIV_W  requested divide ratio N
- load  input  1  one-cycle pulse: capture div_val into shadow register
- clk_div  output  1  divided clock level, registered
- ce_rise  output  1  one-cycle pulse on the first cycle of each period
- ce_fall  output  1  one-cycle pulse on the first low cycle of each period
- tick_cnt  output  2  period counter, +1 per ce_rise, wraps 3->0
- busy  output  1  state != IDLE
- cfg_err  output  1  sticky: a captured ratio was < 2

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; phase cnt 0.
  - Active ratio and shadow ratio = 2.
- State machine IDLE/RUN/STOP:
  - IDLE->RUN when en=1 is sampled at edge k. After edge k: cnt=0, ce_rise=1, clk_div=1, tick_cnt incremented. Latency is 1 cycle.
  - RUN: cnt counts 0..N-1, then wraps to 0. Each wrap to 0 asserts ce_rise and increments tick_cnt.
  - RUN->STOP when en=0 is sampled. Counting continues; the period is always completed.
  - STOP->RUN when en=1 is sampled before the period ends. There is no gap; the next period starts normally.
  - STOP->IDLE at cnt==N-1 with en=0. clk_div, ce_* and cnt are 0 in IDLE; tick_cnt holds its value.
- Waveform for active ratio N, with hi = N>>1:
  - clk_div=1 for cnt 0..hi-1, 0 for cnt hi..N-1. N odd gives the extra cycle to the low phase (N=5: 2 high, 3 low).
  - ce_fall=1 exactly when cnt==hi.
  - All outputs come from flops; no combinational path from inputs to outputs.
- Ratio update:
  - load captures div_val into the shadow register on the same edge.
  - The active ratio takes the shadow value only at a period boundary (cnt N-1 -> 0) or on IDLE->RUN. A period in progress is never shortened or stretched.
  - load and a boundary on the same edge: the new value applies to the period starting at that boundary.
  - load while IDLE: the value is used by the next start.
  - Captured div_val < 2 is clamped to 2 and sets cfg_err. cfg_err clears only on reset.
- cnt width is DIV_W; comparisons are unsigned. tick_cnt wraps modulo 4.
- Asynchronous reset mid-operation clears everything immediately; outputs go low within the reset assertion, with no clock needed.

Decomposition:
- No shared package is needed.
- State encoding (IDLE=0, RUN=1, STOP=2) is a set of localparams in the module.
- One sub-module is natural: div_phase_cnt, holding the cnt register, wrap/boundary detection and the active-ratio update. The FSM and output flops stay in the top.

Test Plan:
- Reset and idle: assert rst_n asynchronously mid-cycle -> all outputs 0 immediately. Release with en=0 -> outputs stay 0 and busy=0.
- N=4 run: load 4, raise en -> clk_div 1,1,0,0 repeating; ce_rise every 4 cycles starting 1 cycle after en; ce_fall at the third cycle of each period; tick_cnt 1,2,3,0,1 across five periods.
- Odd N and ratio change:
  - N=5 -> 2 high / 3 low.
  - Pulse load with 6 at cnt=1 -> the current period still ends after 5 cycles; the next period is 3 high / 3 low.
- Stop and restart:
  - Drop en at cnt=1 (N=4) -> busy stays 1 until the period completes; then IDLE with clk_div=0 and tick_cnt held.
  - Re-raise en while in STOP -> next ce_rise follows immediately after cnt==3, with no idle cycle.
- Clamp: load div_val=1 -> cfg_err=1 and the block runs at N=2 (clk_div 1,0 toggling). cfg_err stays 1 after a later load of 4; cleared only by reset.
